// File: rtl/press_decoder_pkg.sv
// Shared definitions for the press decoder: gesture FSM encoding and
// default timing values (cycles of the 100 MHz system clock).
package press_decoder_pkg;

    localparam int unsigned DEBOUNCE_CYC_DEFAULT = 32'd1000000;   // 10 ms
    localparam int unsigned LONG_CYC_DEFAULT     = 32'd200000000; // 2 s
    localparam int unsigned GAP_CYC_DEFAULT      = 32'd30000000;  // 300 ms

    localparam int TIMER_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT2     = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HELD = 3'd4
    } state_t;

endpackage

// File: rtl/press_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer. The output only
// follows the synchronized input once it has disagreed with the output for
// DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts the count.
module press_debounce
    import press_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam logic [TIMER_W-1:0] DEB_LAST = TIMER_W'(DEBOUNCE_CYC - 32'd1);

    logic              sync1_r;
    logic              sync2_r;
    logic [TIMER_W-1:0] cnt_r;
    logic              level_r;

    // Metastability guard: the raw button is asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreeing cycles and flip the level when the run completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {TIMER_W{1'b0}};
            level_r <= 1'b0;
        end else if (sync2_r != level_r) begin
            if (cnt_r == DEB_LAST) begin
                cnt_r   <= {TIMER_W{1'b0}};
                level_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + TIMER_W'(1);
                level_r <= level_r;
            end
        end else begin
            cnt_r   <= {TIMER_W{1'b0}};
            level_r <= level_r;
        end
    end

    assign out = level_r;

endmodule

// File: rtl/press_decoder.sv
// Button gesture decoder: debounces a raw button and classifies each gesture
// as a single click, double click or long press. Strobes and held are
// registered alongside the state transition that produces them.
module press_decoder
    import press_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int unsigned LONG_CYC     = LONG_CYC_DEFAULT,
    parameter int unsigned GAP_CYC      = GAP_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic press,
    output logic pressed,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic held
);

    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYC - 32'd1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYC - 32'd1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};

    logic               pressed_s;
    state_t             state_r;
    state_t             state_next_s;
    logic [TIMER_W-1:0] timer_r;
    logic               short_s;
    logic               double_s;
    logic               long_s;
    logic               short_r;
    logic               double_r;
    logic               long_r;
    logic               held_r;

    press_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk (clk),
        .rst (rst),
        .in  (press),
        .out (pressed_s)
    );

    // Gesture classification; a pressed edge always wins over a timer threshold.
    always_comb begin
        state_next_s = state_r;
        short_s      = 1'b0;
        double_s     = 1'b0;
        long_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pressed_s) begin
                    state_next_s = ST_PRESS1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (!pressed_s) begin
                    state_next_s = ST_WAIT2;
                end else if (timer_r == LONG_LAST) begin
                    long_s       = 1'b1;
                    state_next_s = ST_LONG_HELD;
                end else begin
                    state_next_s = ST_PRESS1;
                end
            end
            ST_WAIT2: begin
                if (pressed_s) begin
                    state_next_s = ST_PRESS2;
                end else if (timer_r == GAP_LAST) begin
                    short_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT2;
                end
            end
            ST_PRESS2: begin
                if (!pressed_s) begin
                    double_s     = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (timer_r == LONG_LAST) begin
                    long_s       = 1'b1;
                    state_next_s = ST_LONG_HELD;
                end else begin
                    state_next_s = ST_PRESS2;
                end
            end
            ST_LONG_HELD: begin
                if (!pressed_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LONG_HELD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and the single phase timer (restarts on every transition, saturates).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            timer_r <= {TIMER_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                timer_r <= {TIMER_W{1'b0}};
            end else if (timer_r != TIMER_MAX) begin
                timer_r <= timer_r + TIMER_W'(1);
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Registered strobes and held level, aligned with the state they announce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            held_r   <= 1'b0;
        end else begin
            short_r  <= short_s;
            double_r <= double_s;
            long_r   <= long_s;
            held_r   <= (state_next_s == ST_LONG_HELD);
        end
    end

    assign pressed      = pressed_s;
    assign short_pulse  = short_r;
    assign double_pulse = double_r;
    assign long_pulse   = long_r;
    assign held         = held_r;

endmodule

// File: tb/tb_press_decoder.sv
// Self-checking bench for press_decoder with short timing parameters.
// A gesture-level reference model runs alongside the DUT every cycle; a table
// of scenarios carries hand-derived gesture counts; reset and threshold
// boundaries get dedicated sequences; random press trains finish the run.
module tb_press_decoder;

    localparam int DEB = 4;
    localparam int LNG = 100;
    localparam int GAP = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic press = 1'b0;
    logic pressed, short_pulse, double_pulse, long_pulse, held;

    always #5 clk = ~clk;

    press_decoder #(
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LNG),
        .GAP_CYC      (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .press        (press),
        .pressed      (pressed),
        .short_pulse  (short_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .held         (held)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    // reference model: raw-sample history, debounced level, gesture description
    bit m_s1, m_s2, m_pressed;
    int m_run;
    bit g_active, g_down, g_long;
    int g_clicks, g_el;
    bit m_short, m_double, m_long, m_held;

    // observed gesture statistics
    int c_rise, c_short, c_double, c_long;
    bit c_held, prev_pressed;

    typedef struct {
        string name;
        int    seg[4];   // alternating high/low lengths, 0 ends the list
        int    e_rise;
        int    e_short;
        int    e_double;
        int    e_long;
        bit    e_held;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_print < 25) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
            n_print++;
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_pressed = 0; m_run = 0;
        g_active = 0; g_down = 0; g_long = 0; g_clicks = 0; g_el = 0;
        m_short = 0; m_double = 0; m_long = 0; m_held = 0;
    endtask

    // One clock of the model: classify on the previous debounced level,
    // then advance the debouncer and the sample history.
    task automatic model_step(input bit raw);
        m_short = 0; m_double = 0; m_long = 0;
        if (!g_active) begin
            if (m_pressed) begin
                g_active = 1; g_clicks = 1; g_down = 1; g_long = 0; g_el = 0;
            end
        end else if (g_long) begin
            if (!m_pressed) g_active = 0;
        end else if (g_down) begin
            if (!m_pressed) begin
                if (g_clicks == 1) begin g_down = 0; g_el = 0; end
                else begin m_double = 1; g_active = 0; end
            end else if (g_el == LNG - 1) begin
                m_long = 1; g_long = 1; g_el = 0;
            end else g_el++;
        end else begin
            if (m_pressed) begin
                g_clicks = 2; g_down = 1; g_el = 0;
            end else if (g_el == GAP - 1) begin
                m_short = 1; g_active = 0;
            end else g_el++;
        end
        m_held = g_active && g_long;
        if (m_s2 != m_pressed) begin
            m_run++;
            if (m_run == DEB) begin m_pressed = m_s2; m_run = 0; end
        end else m_run = 0;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic clear_stats();
        c_rise = 0; c_short = 0; c_double = 0; c_long = 0; c_held = 0;
    endtask

    // Advance one clock, then compare every output with the model.
    task automatic cycle();
        int strobes;
        @(posedge clk);
        if (!rst) model_reset();
        else model_step(press);
        #1;
        check("outputs{pressed,short,double,long,held}",
              int'({pressed, short_pulse, double_pulse, long_pulse, held}),
              int'({m_pressed, m_short, m_double, m_long, m_held}));
        strobes = int'(short_pulse) + int'(double_pulse) + int'(long_pulse);
        check("strobe_exclusive", int'(strobes <= 1), 1);
        if (pressed && !prev_pressed) c_rise++;
        prev_pressed = pressed;
        c_short  += int'(short_pulse);
        c_double += int'(double_pulse);
        c_long   += int'(long_pulse);
        if (held) c_held = 1;
    endtask

    task automatic drive(input bit lvl, input int len);
        press = lvl;
        for (int k = 0; k < len; k++) cycle();
    endtask

    task automatic run_segments(input int s0, input int s1, input int s2, input int s3);
        int s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            if (s[k] == 0) break;
            drive(k % 2 == 0, s[k]);
        end
        drive(1'b0, 80);
    endtask

    initial begin
        int first;
        tbl[0] = '{"glitch_single", '{1, 1, 48, 0},  1, 1, 0, 0, 0};
        tbl[1] = '{"double",        '{20, 10, 20, 0}, 2, 0, 1, 0, 0};
        tbl[2] = '{"long",          '{150, 0, 0, 0},  1, 0, 0, 1, 1};
        tbl[3] = '{"press_then_long", '{20, 10, 150, 0}, 2, 0, 0, 1, 1};

        model_reset();
        prev_pressed = 0;
        clear_stats();
        cycle();
        cycle();
        check("reset_outputs", int'({pressed, short_pulse, double_pulse, long_pulse, held}), 0);
        rst = 1'b1;
        drive(1'b0, 5);

        // scenario table with hand-derived gesture counts
        for (int t = 0; t < 4; t++) begin
            clear_stats();
            run_segments(tbl[t].seg[0], tbl[t].seg[1], tbl[t].seg[2], tbl[t].seg[3]);
            check({tbl[t].name, "_rises"},  c_rise,   tbl[t].e_rise);
            check({tbl[t].name, "_short"},  c_short,  tbl[t].e_short);
            check({tbl[t].name, "_double"}, c_double, tbl[t].e_double);
            check({tbl[t].name, "_long"},   c_long,   tbl[t].e_long);
            check({tbl[t].name, "_held"},   int'(c_held), int'(tbl[t].e_held));
        end

        // reset in the middle of a first press, button kept down
        press = 1'b1;
        for (int k = 0; k < 20 && !pressed; k++) cycle();
        check("pressed_before_reset", int'(pressed), 1);
        drive(1'b1, 10);
        #2;
        rst = 1'b0;
        #1;
        check("rst_immediate", int'({pressed, short_pulse, double_pulse, long_pulse, held}), 0);
        model_reset();
        cycle();
        cycle();
        rst = 1'b1;
        clear_stats();
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (pressed && first == 0) first = k;
        end
        check("rst_repress_cycle", first, 2 + DEB);
        drive(1'b0, 80);
        check("rst_after_short", c_short, 1);
        check("rst_after_long",  c_long, 0);

        // boundaries: release-to-press gap and long-press length around thresholds
        for (int g = GAP - 8; g <= GAP + 4; g++) run_segments(20, g, 20, 0);
        for (int h = LNG - 4; h <= LNG + 6; h++) run_segments(h, 0, 0, 0);
        for (int h = LNG - 4; h <= LNG + 6; h++) run_segments(15, 12, h, 0);

        // random press trains
        for (int r = 0; r < 300; r++) begin
            int len;
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(90, 130));
            else len = int'($urandom_range(1, 40));
            drive(r % 2 == 0, len);
        end
        drive(1'b0, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/press_decoder.md
PRESS_DECODER -- requirements
Module: press_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 1000000, cycles raw input must hold a new level before accepted (10 ms at 100 MHz).
REQ-002 SHALL have parameter LONG_CYC, default 200000000, debounced-high cycles that qualify a long press.
REQ-003 SHALL have parameter GAP_CYC, default 30000000, maximum release-to-second-press cycles for a double click.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: press  input  1  raw, asynchronous, bouncing button level, 1 = pressed.
REQ-007 SHALL have port: pressed  output  1  debounced button level.
REQ-008 SHALL have port: short_pulse  output  1  one-cycle strobe, single click classified.
REQ-009 SHALL have port: double_pulse  output  1  one-cycle strobe, double click classified.
REQ-010 SHALL have port: long_pulse  output  1  one-cycle strobe, long press qualified.
REQ-011 SHALL have port: held  output  1  level, high while a qualified long press is still held.

Function
REQ-012 SHALL pass press through a 2-flop synchronizer before any other use.
REQ-013 SHALL change pressed only after the synchronized input differs from pressed for DEBOUNCE_CYC consecutive cycles; any agreeing cycle clears the debounce count.
REQ-014 SHALL run FSM states IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD on pressed, with one 32-bit timer cleared on every state change and saturating at all-ones.
REQ-015 IDLE: pressed rise -> PRESS1.
REQ-016 PRESS1: timer reaching LONG_CYC-1 while pressed -> long_pulse, LONG_HELD; pressed fall earlier -> WAIT2.
REQ-017 WAIT2: pressed rise before timer reaches GAP_CYC-1 -> PRESS2; timer reaching GAP_CYC-1 -> short_pulse, IDLE.
REQ-018 PRESS2: pressed fall -> double_pulse, IDLE; timer reaching LONG_CYC-1 while pressed -> long_pulse only, LONG_HELD.
REQ-019 LONG_HELD: held = 1; pressed fall -> IDLE with no strobe.
REQ-020 SHALL register all outputs; each strobe exactly one cycle, at most one strobe per cycle, strobes mutually exclusive per gesture.
REQ-021 SHALL resolve a cycle where the timer threshold and a pressed edge coincide in favour of the edge.

Reset
REQ-022 SHALL on rst low immediately force pressed, short_pulse, double_pulse, long_pulse, held to 0, FSM to IDLE, synchronizer, debounce counter and timer to 0.
REQ-023 SHALL abandon any in-progress gesture on reset with no strobe; a button still held at reset release counts as a new press after 2 + DEBOUNCE_CYC cycles.

Structure
REQ-024 SHALL place FSM state encoding and default values of DEBOUNCE_CYC, LONG_CYC, GAP_CYC in the shared package.
REQ-025 SHALL implement synchronizer plus debounce as sub-module press_debounce (clk, rst, in, out), instantiated once.

Verification (DEBOUNCE_CYC=4, LONG_CYC=100, GAP_CYC=30)
REQ-026 press high 50 cycles with 1-cycle glitches in first 3, then low -> pressed rises once; short_pulse one cycle about 30 cycles after pressed falls; no other strobe.
REQ-027 press 20 high, 10 low, 20 high, low -> double_pulse one cycle when second pressed falls; short_pulse never.
REQ-028 press high 150 cycles -> long_pulse 100 cycles after pressed rises, held high until pressed falls, no short/double afterwards.
REQ-029 press 20 high, 10 low, 150 high -> long_pulse only, held asserted; no double_pulse.
REQ-030 rst low mid-PRESS1, press kept high -> all outputs 0 at once; after rst high, pressed returns at cycle 6 and classification restarts.
